// File: rtl/tdm_demux4_pkg.sv
// Shared types and constants for the 4-slot TDM demultiplexer.
// Holds the framing FSM states and the slot counter geometry.
package tdm_demux4_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);

  localparam logic [SLOT_W-1:0] FIRST_SLOT = SLOT_W'(0);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot counter: load-to-1 marks "slot 0 just consumed", increment
// advances one slot and wraps from the last slot back to 0.
module tdm_slot_ctr
  import tdm_demux4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  input  logic              load1_i,
  output logic [SLOT_W-1:0] slot_o
);

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  always_comb begin
    slot_d = slot_q;
    if (load1_i) begin
      slot_d = SLOT_W'(1);
    end else if (inc_i) begin
      slot_d = slot_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= FIRST_SLOT;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// Splits a framed serial slot stream (a,b,c,d) into four registered channels.
// Input handshake: a sample is taken on every rising edge where en=1; sync=1 on that edge marks slot a.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH-1:0] o_c,
  output logic [WIDTH-1:0] o_d,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked
);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot;
  logic              slot_inc, slot_load1;

  logic [WIDTH-1:0]  sh_a_q, sh_a_d;
  logic [WIDTH-1:0]  sh_b_q, sh_b_d;
  logic [WIDTH-1:0]  sh_c_q, sh_c_d;
  logic [WIDTH-1:0]  out_a_q, out_a_d;
  logic [WIDTH-1:0]  out_b_q, out_b_d;
  logic [WIDTH-1:0]  out_c_q, out_c_d;
  logic [WIDTH-1:0]  out_d_q, out_d_d;
  logic              fv_q, fv_d;
  logic              err_q, err_d;

  tdm_slot_ctr u_slot_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (slot_inc),
    .load1_i (slot_load1),
    .slot_o  (slot)
  );

  always_comb begin
    state_d    = state_q;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    sh_c_d     = sh_c_q;
    out_a_d    = out_a_q;
    out_b_d    = out_b_q;
    out_c_d    = out_c_q;
    out_d_d    = out_d_q;
    fv_d       = 1'b0;
    err_d      = 1'b0;
    slot_inc   = 1'b0;
    slot_load1 = 1'b0;

    if (en) begin
      if (state_q == HUNT) begin
        if (sync) begin
          sh_a_d     = din;
          slot_load1 = 1'b1;
          state_d    = LOCKED;
        end
      end else if (sync) begin
        // Early sync drops the partial frame; stale b/c shadows are rewritten before use.
        err_d      = (slot != FIRST_SLOT);
        sh_a_d     = din;
        slot_load1 = 1'b1;
      end else if (slot == FIRST_SLOT) begin
        err_d   = 1'b1;
        state_d = HUNT;
      end else if (slot == LAST_SLOT) begin
        out_a_d  = sh_a_q;
        out_b_d  = sh_b_q;
        out_c_d  = sh_c_q;
        out_d_d  = din;
        fv_d     = 1'b1;
        slot_inc = 1'b1;
      end else begin
        if (slot == SLOT_W'(1)) begin
          sh_b_d = din;
        end else begin
          sh_c_d = din;
        end
        slot_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_c_q  <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
      out_c_q <= '0;
      out_d_q <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_c_q  <= sh_c_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      out_c_q <= out_c_d;
      out_d_q <= out_d_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  assign o_a         = out_a_q;
  assign o_b         = out_b_q;
  assign o_c         = out_c_q;
  assign o_d         = out_d_q;
  assign frame_valid = fv_q;
  assign sync_err    = err_q;
  assign locked      = (state_q == LOCKED);

endmodule
